// File: rtl/ram_bank_ctrl_if.sv
// Request/response and RAM-bank bus for ram_bank_ctrl.
// slave = controller side, master = requester plus RAM banks.
interface ram_bank_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_BITS  = 2
);
  localparam int NUM_BANKS = 2**BANK_BITS;
  localparam int BA_W      = ADDR_WIDTH - BANK_BITS;

  logic                          req_valid;
  logic                          req_ready;
  logic                          req_write;
  logic [ADDR_WIDTH-1:0]         req_addr;
  logic [DATA_WIDTH-1:0]         req_wdata;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic [NUM_BANKS-1:0]          mem_bank_sel;
  logic                          mem_write_en;
  logic [BA_W-1:0]               mem_addr;
  logic [DATA_WIDTH-1:0]         mem_write_data;
  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_bank_sel, mem_write_en, mem_addr, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_bank_sel, mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/ram_bank_ctrl.sv
// Banked RAM controller: 1-cycle writes, 3-cycle read round trip.
// Ports: clock, reset_n, bus (ram_bank_ctrl_if.slave). With macro
// RAM_BANK_CTRL_STATS_EN: wr_count, rd_count saturating counters.
module ram_bank_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int BANK_BITS  = 2
) (
  input  logic clock,
  input  logic reset_n,
  ram_bank_ctrl_if.slave bus
`ifdef RAM_BANK_CTRL_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
`endif
);
  localparam int NUM_BANKS = 2**BANK_BITS;
  localparam int BA_W      = ADDR_WIDTH - BANK_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [BANK_BITS-1:0]  bank_q, bank_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  idle;
  logic                  accept;
  logic                  rsp_hs;
  logic [BANK_BITS-1:0]  req_bank;
  logic [BA_W-1:0]       req_word;

  logic [NUM_BANKS-1:0]  sel;
  logic                  wen;
  logic [BA_W-1:0]       maddr;
  logic [DATA_WIDTH-1:0] mwdata;

  assign idle     = (state_q == IDLE);
  // reset_n gating keeps the RAM quiet while reset is held
  assign accept   = idle & reset_n & bus.req_valid;
  assign rsp_hs   = (state_q == RSP) & bus.rsp_ready;
  assign req_bank = bus.req_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign req_word = bus.req_addr[BA_W-1:0];

  // RAM side is a combinational pass-through of the accepted request
  always_comb begin
    sel    = '0;
    wen    = 1'b0;
    maddr  = '0;
    mwdata = '0;
    if (accept) begin
      sel[req_bank] = 1'b1;
      wen           = bus.req_write;
      maddr         = req_word;
      mwdata        = bus.req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !bus.req_write) begin
          state_d = RD_WAIT;
          bank_d  = req_bank;
        end
      end
      RD_WAIT: begin
        // bank has registered its word; take our slice
        rdata_d = bus.mem_read_data[bank_q*DATA_WIDTH +: DATA_WIDTH];
        state_d = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bank_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready      = idle & reset_n;
  assign bus.rsp_valid      = (state_q == RSP);
  assign bus.rsp_rdata      = rdata_q;
  assign bus.mem_bank_sel   = sel;
  assign bus.mem_write_en   = wen;
  assign bus.mem_addr       = maddr;
  assign bus.mem_write_data = mwdata;

`ifdef RAM_BANK_CTRL_STATS_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (accept && bus.req_write && wr_cnt_q != 16'hFFFF)
      wr_cnt_d = wr_cnt_q + 16'd1;
    if (rsp_hs && rd_cnt_q != 16'hFFFF)
      rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: doc/ram_bank_ctrl.md
RAM_BANK_CTRL -- requirements
Module: ram_bank_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, total word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 The block SHALL have parameter BANK_BITS, default 2, with NUM_BANKS = 2**BANK_BITS and bank address width BA_W = ADDR_WIDTH-BANK_BITS.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports:
  clock  input  1  sole clock, rising edge
  reset_n  input  1  asynchronous active-low reset
  req_valid  input  1  request present
  req_ready  output  1  request accepted when req_valid and req_ready are both high
  req_write  input  1  1 = write, 0 = read
  req_addr  input  ADDR_WIDTH  bank = req_addr[ADDR_WIDTH-1 -: BANK_BITS], word = low BA_W bits
  req_wdata  input  DATA_WIDTH  write data
  rsp_valid  output  1  read data available
  rsp_ready  input  1  consumer takes rsp_rdata
  rsp_rdata  output  DATA_WIDTH  read data
  mem_bank_sel  output  NUM_BANKS  one-hot bank select to the RAM banks
  mem_write_en  output  1  write strobe to the RAM banks
  mem_addr  output  BA_W  word address to the RAM banks
  mem_write_data  output  DATA_WIDTH  write data to the RAM banks
  mem_read_data  input  NUM_BANKS*DATA_WIDTH  bank i at [i*DATA_WIDTH +: DATA_WIDTH], registered by bank one clock after select

Function
REQ-005 The FSM SHALL have three states: IDLE, RD_WAIT and RSP.
REQ-006 req_ready SHALL be 1 only in IDLE, and 0 in RD_WAIT and RSP.
REQ-007 In IDLE, while req_valid=1, mem_bank_sel, mem_addr, mem_write_data and mem_write_en SHALL be driven combinationally from the request in the same cycle (mem_write_en = req_write).
REQ-008 When no request is accepted, mem_bank_sel SHALL be all-zero and mem_write_en SHALL be 0.
REQ-009 An accepted write SHALL complete in its accept cycle, leave the FSM in IDLE, and produce no response.
REQ-010 Back-to-back writes SHALL sustain one per cycle.
REQ-011 An accepted read SHALL store the bank index and move the FSM to RD_WAIT.
REQ-012 In RD_WAIT, the block SHALL capture the stored bank's slice of mem_read_data into rsp_rdata and move to RSP.
REQ-013 In RSP, rsp_valid SHALL be 1 and rsp_rdata SHALL stay stable until rsp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-014 Read latency SHALL be: accept at edge k, then rsp_valid=1 from edge k+2.
REQ-015 The next request SHALL be accepted no earlier than the cycle after the response handshake, so the minimum read period is 3 cycles.
REQ-016 rsp_ready asserted while rsp_valid=0 SHALL have no effect.
REQ-017 req_* inputs SHALL be ignored outside IDLE, and no RAM access SHALL occur in RD_WAIT or RSP.
REQ-018 Exactly one mem_bank_sel bit SHALL be high during any access.

Reset
REQ-019 While reset_n=0, state SHALL be IDLE, rsp_valid=0, rsp_rdata=0, stored bank=0, and all mem_* outputs SHALL be 0.
REQ-020 A reset asserted in RD_WAIT or RSP SHALL abandon the read: no response is produced after release, and req_ready=1 in the first cycle after release.

Configuration
REQ-021 With macro RAM_BANK_CTRL_STATS_EN defined, the block SHALL add outputs wr_count (16 bits) and rd_count (16 bits), incremented on each accepted write and each completed response handshake respectively, saturating at 16'hFFFF and cleared by reset.
REQ-022 Without RAM_BANK_CTRL_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Write addr 6'h2A, data 32'hDEADBEEF -> same cycle: mem_bank_sel=4'b0100, mem_addr=4'hA, mem_write_en=1; no rsp_valid.
REQ-024 Read addr 6'h2A with a bank-2 model holding 32'hDEADBEEF, rsp_ready=1 -> rsp_valid at accept+2 with rsp_rdata=32'hDEADBEEF; req_ready low for 2 cycles.
REQ-025 Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable for 5 cycles; req_ready=0 throughout; req_valid pulses cause no mem_bank_sel activity.
REQ-026 Four back-to-back writes to banks 0..3 -> one access per cycle, mem_bank_sel 0001, 0010, 0100, 1000.
REQ-027 reset_n pulsed low in RD_WAIT -> rsp_valid never asserts; req_ready=1 on the first cycle after release.
REQ-028 With RAM_BANK_CTRL_STATS_EN, 3 writes and 2 completed reads -> wr_count=3, rd_count=2; forced to 16'hFFFF, a further write holds wr_count at 16'hFFFF.
